// File: rtl/nco_pkg.sv
// Shared types and widths for the NCO frequency-control path.
// Latency: n/a (package only).
// Backpressure: n/a.
package nco_pkg;

    // Frequency word width of the sine generator's freq_control input.
    localparam int FW_DEFAULT = 16;
    // Dwell counter width; dwell up to 2^DW cycles per frequency.
    localparam int DW_DEFAULT = 24;
    // Width shared with the sine generator's freq_control port.
    localparam int NCO_FREQ_CONTROL_W = FW_DEFAULT;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/nco_dwell_timer.sv
// Down-counting dwell timer: load a hold count, count to zero, flag expiry.
// Latency: expire reflects the registered count (combinational off the register).
// Backpressure: none; load has priority over enable, clear over load.
module nco_dwell_timer #(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    input  logic          en,
    output logic          expire
);

    logic [DW-1:0] cnt;

    // Counter register: clear/reset to zero, reload, or decrement toward zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - {{(DW-1){1'b0}}, 1'b1};
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/nco_sweep_controller.sv
// Linear frequency sweep sequencer driving the NCO freq_control word.
// Latency: start sampled in cycle T, first word out at T+1, then every dwell+1 cycles.
// Backpressure: none; start ignored while busy, abort wins over start.
module nco_sweep_controller
    import nco_pkg::*;
#(
    parameter int FW = FW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] cfg_start_freq,
    input  logic [FW-1:0] cfg_stop_freq,
    input  logic [FW-1:0] cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_pingpong,
    input  logic          start,
    input  logic          abort,
    output logic [FW-1:0] freq_word,
    output logic          busy,
    output logic          step_strobe,
    output logic          sweep_done
);

    state_t        state, state_nxt;
    dir_t          dir_r, dir_nxt, step_dir;
    logic [FW-1:0] orig_r, orig_nxt;     // endpoint the sweep is moving away from
    logic [FW-1:0] tgt_r, tgt_nxt;       // endpoint the sweep is moving toward
    logic [FW-1:0] step_r, step_nxt;
    logic [DW-1:0] dwell_r, dwell_nxt;
    logic          pp_r, pp_nxt;
    logic [FW-1:0] freq_nxt;
    logic          strobe_nxt, done_nxt;

    logic          tmr_clr, tmr_load, tmr_en, tmr_expire;
    logic [DW-1:0] tmr_load_val;

    logic          bounce;
    logic [FW-1:0] step_tgt, stepped;
    logic [FW:0]   sum, diff;

    nco_dwell_timer #(.DW(DW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // At an endpoint in ping-pong mode the step heads back toward the other end.
    assign bounce = tmr_expire && (freq_word == tgt_r) && pp_r;

    // Next frequency one step toward the target, clamped so it never passes or wraps.
    always_comb begin
        step_tgt = bounce ? orig_r : tgt_r;
        step_dir = bounce ? ((dir_r == DIR_UP) ? DIR_DOWN : DIR_UP) : dir_r;
        sum      = {1'b0, freq_word} + {1'b0, step_r};
        diff     = {1'b0, freq_word} - {1'b0, step_r};
        stepped  = freq_word;
        if (step_dir == DIR_UP) begin
            stepped = (sum > {1'b0, step_tgt}) ? step_tgt : sum[FW-1:0];
        end else begin
            stepped = (diff[FW] || (diff[FW-1:0] < step_tgt)) ? step_tgt : diff[FW-1:0];
        end
    end

    // Next-state and output decode for the IDLE/RUN sequencer.
    always_comb begin
        state_nxt    = state;
        dir_nxt      = dir_r;
        orig_nxt     = orig_r;
        tgt_nxt      = tgt_r;
        step_nxt     = step_r;
        dwell_nxt    = dwell_r;
        pp_nxt       = pp_r;
        freq_nxt     = freq_word;
        strobe_nxt   = 1'b0;
        done_nxt     = 1'b0;
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = dwell_r;
        tmr_en       = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        orig_nxt     = cfg_start_freq;
                        tgt_nxt      = cfg_stop_freq;
                        step_nxt     = (cfg_step == '0) ? {{(FW-1){1'b0}}, 1'b1} : cfg_step;
                        dwell_nxt    = cfg_dwell;
                        pp_nxt       = cfg_pingpong;
                        dir_nxt      = (cfg_stop_freq >= cfg_start_freq) ? DIR_UP : DIR_DOWN;
                        freq_nxt     = cfg_start_freq;
                        strobe_nxt   = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = cfg_dwell;
                        state_nxt    = RUN;
                    end
                end
                RUN: begin
                    if (!tmr_expire) begin
                        tmr_en = 1'b1;
                    end else if (freq_word != tgt_r) begin
                        freq_nxt   = stepped;
                        strobe_nxt = 1'b1;
                        tmr_load   = 1'b1;
                    end else if (!pp_r) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        orig_nxt   = tgt_r;
                        tgt_nxt    = orig_r;
                        dir_nxt    = step_dir;
                        freq_nxt   = stepped;
                        strobe_nxt = 1'b1;
                        tmr_load   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register plus latched sweep configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dir_r       <= DIR_UP;
            orig_r      <= '0;
            tgt_r       <= '0;
            step_r      <= '0;
            dwell_r     <= '0;
            pp_r        <= 1'b0;
            freq_word   <= '0;
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_r       <= dir_nxt;
            orig_r      <= orig_nxt;
            tgt_r       <= tgt_nxt;
            step_r      <= step_nxt;
            dwell_r     <= dwell_nxt;
            pp_r        <= pp_nxt;
            freq_word   <= freq_nxt;
            step_strobe <= strobe_nxt;
            sweep_done  <= done_nxt;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: doc/nco_sweep_controller.md
Name: nco_sweep_controller

Overview:
- Sequences the 16-bit frequency control word of the phase-accumulator sine generator.
- Performs programmable linear frequency sweeps: start frequency, stop frequency, step size and dwell time, in one-shot or ping-pong mode.
- Sits between the host/register interface and the sine generator's freq_control input.
- Runs on the same 125 MHz clock domain as the sine generator.

Parameters:
- FW, 16, frequency word width; matches the NCO freq_control width.
- DW, 24, dwell counter width; maximum dwell is 2^DW cycles per frequency.

Ports:
- clk  input  1  system clock (125 MHz).
- rst  input  1  synchronous reset, active-high.
- cfg_start_freq  input  FW  first frequency word of the sweep.
- cfg_stop_freq  input  FW  last frequency word of the sweep.
- cfg_step  input  FW  step magnitude; 0 is treated as 1.
- cfg_dwell  input  DW  extra hold cycles per frequency; each frequency is held cfg_dwell+1 cycles.
- cfg_pingpong  input  1  0 = one-shot sweep, 1 = bounce between endpoints until abort.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  stop sweep immediately.
- freq_word  output  FW  drives the NCO freq_control input.
- busy  output  1  high while a sweep is running.
- step_strobe  output  1  one-cycle pulse coincident with every freq_word update.
- sweep_done  output  1  one-cycle pulse when a one-shot sweep completes.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: freq_word=0, busy=0, step_strobe=0, sweep_done=0, state=IDLE, dwell counter=0.
- States:
  - IDLE: waits for start.
  - RUN: counts dwell and steps the frequency.
- IDLE behaviour:
  - start=1 && abort=0 in cycle T: latch all cfg_* into internal registers.
  - dir = up if cfg_stop_freq >= cfg_start_freq, otherwise down.
  - At T+1: freq_word=cfg_start_freq, busy=1, step_strobe=1; dwell counter = cfg_dwell; state goes to RUN.
  - cfg_* changes after T have no effect on the running sweep.
- RUN behaviour:
  - Counter != 0: decrement; freq_word holds.
  - Counter == 0 and freq_word != target: freq_word = freq_word ± step, per dir. Reload the counter; pulse step_strobe.
  - Clamp: compute the next value in FW+1 bits. If it passes the target (including wrap past 0 or 2^FW-1), freq_word = target exactly.
  - Counter == 0 and freq_word == target, cfg_pingpong=0:
    - Next cycle: busy=0, sweep_done=1 for one cycle, state goes to IDLE.
    - freq_word holds the stop value, so the NCO keeps running at the stop frequency.
  - Counter == 0 and freq_word == target, cfg_pingpong=1:
    - Invert dir and swap the latched endpoints, so target becomes the other endpoint.
    - Step immediately with clamping, pulse step_strobe, reload the counter.
- Timing: updates occur at T+1+k*(cfg_dwell+1), k = 0,1,2,...
- Degenerate cases:
  - start_freq == stop_freq, one-shot: the start value is held cfg_dwell+1 cycles, then done.
  - start_freq == stop_freq, ping-pong: the value is held forever, step_strobe pulses every cfg_dwell+1 cycles, and no value change occurs.
  - cfg_dwell=0: freq_word updates every cycle.
- abort:
  - Any state: next cycle busy=0, state=IDLE, counter cleared, step_strobe=0, no sweep_done.
  - freq_word holds its current value.
  - abort and start in the same IDLE cycle: abort wins, sweep not started.
- start while busy: ignored.
- rst mid-sweep: all outputs return to reset values next cycle, including freq_word=0 (NCO silenced at DC).
- sweep_done and step_strobe never assert in the same cycle.

Decomposition:
- Shared package (nco_pkg):
  - FW_DEFAULT=16 and DW_DEFAULT=24.
  - State enum {IDLE, RUN}.
  - Direction enum {DIR_UP, DIR_DOWN}.
  - Width constants shared with the sine generator's freq_control.
- Sub-module nco_dwell_timer:
  - Inputs: load, load value, enable.
  - Output: expire flag.
  - The counter is reusable by future burst/gating controllers.
- Step/clamp arithmetic stays inline.

Test Plan:
- Reset, then start with start=100, stop=140, step=10, dwell=2, one-shot.
  - Required: freq_word = 100, 110, 120, 130, 140, each held 3 cycles.
  - step_strobe pulses 5 times; sweep_done pulses 3 cycles after the 140 strobe; busy falls in the same cycle.
- Down sweep with clamp: start=0x0010, stop=0x0003, step=5, dwell=0.
  - Required sequence: 0x10, 0x0B, 0x06, 0x03, then done. No wrap below 0.
- Overflow clamp: start=0xFFF0, stop=0xFFFF, step=0x0020, dwell=1.
  - Required sequence: 0xFFF0, 0xFFFF, then done. Never 0x0010.
- Ping-pong: start=10, stop=30, step=10, dwell=0.
  - Required sequence: 10, 20, 30, 20, 10, 20, ...
  - busy stays 1; abort asserted at value 20 gives busy=0 next cycle, freq_word stays 20, no sweep_done.
- Handshake corners:
  - start and abort in the same IDLE cycle gives busy=0.
  - start during RUN does not change the sequence.
  - Changing cfg_stop_freq mid-sweep has no effect.
  - step=0 behaves as step=1.
- rst asserted mid-sweep, then released: freq_word=0 and busy=0 next cycle; a new start then behaves normally.
